// File: rtl/crypto_stream_decrypt_pkg.sv
// Shared definitions for the XOR-keystream encryptor/decryptor pair:
// LFSR taps, FSM state encoding and keystream helper functions.
package crypto_pkg;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK
    } state_e;

    function automatic logic [7:0] ks_next(input logic [7:0] ks);
        return {1'b0, ks[7:1]} ^ (ks[0] ? LFSR_TAPS : 8'h00);
    endfunction

    // An all-zero seed would lock the LFSR at zero.
    function automatic logic [7:0] seed_fix(input logic [7:0] seed);
        return (seed == '0) ? 8'h01 : seed;
    endfunction

endpackage

// File: rtl/crypto_stream_decrypt_keystream.sv
// Keystream register: loads the fixed-up seed at frame start and
// advances one Galois LFSR step per consumed payload byte.
module crypto_keystream
    import crypto_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] ks
);

    logic [7:0] ks_d;
    logic [7:0] ks_q;

    always_comb begin
        ks_d = ks_q;
        if (load) begin
            ks_d = seed_fix(seed);
        end else if (advance) begin
            ks_d = ks_next(ks_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_q <= 8'h01;
        end else begin
            ks_q <= ks_d;
        end
    end

    assign ks = ks_q;

endmodule

// File: rtl/crypto_stream_decrypt.sv
// Receive-side stream decryptor: header/payload/checksum framing, keystream
// XOR, registered plaintext output and per-frame done/error pulses.
module crypto_stream_decrypt
    import crypto_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] key_seed,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_sof,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     state_d, state_q;
    logic [7:0] len_d, len_q;
    logic [7:0] cnt_d, cnt_q;
    logic [7:0] csum_d, csum_q;
    logic       m_valid_d, m_valid_q;
    logic [7:0] m_data_d, m_data_q;
    logic       m_last_d, m_last_q;
    logic       done_d, done_q;
    logic       err_d, err_q;
    logic       run_q;

    logic       ks_load;
    logic       ks_adv;
    logic [7:0] ks;
    logic [7:0] plain;
    logic       accept;

    crypto_keystream u_keystream (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ks_load),
        .advance (ks_adv),
        .seed    (key_seed),
        .ks      (ks)
    );

    // run_q keeps s_ready low until the first edge after reset release.
    always_comb begin
        s_ready = 1'b0;
        if (run_q && enable) begin
            s_ready = (state_q != PAYLOAD) || !m_valid_q || m_ready;
        end
    end

    assign accept = s_valid && s_ready;
    assign plain  = s_data ^ ks;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        m_valid_d = m_valid_q && !m_ready;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ks_load   = 1'b0;
        ks_adv    = 1'b0;

        if (accept && s_sof) begin
            // A header mid-frame aborts the old frame and starts a new one.
            if (state_q != IDLE) begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            if (s_data == '0 || s_data > MAX_LEN_B) begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                len_d   = s_data;
                cnt_d   = '0;
                csum_d  = '0;
                ks_load = 1'b1;
                state_d = PAYLOAD;
            end
        end else if (accept) begin
            unique case (state_q)
                IDLE: begin
                end
                PAYLOAD: begin
                    ks_adv    = 1'b1;
                    csum_d    = csum_q ^ plain;
                    cnt_d     = cnt_q + 8'd1;
                    m_valid_d = 1'b1;
                    m_data_d  = plain;
                    m_last_d  = (cnt_q == len_q - 8'd1);
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    done_d  = 1'b1;
                    err_d   = (plain != csum_q);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            err_q     <= err_d;
            run_q     <= 1'b1;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign m_last     = m_last_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_crypto_stream_decrypt.sv
// Directed bench for crypto_stream_decrypt with a scoreboard of expected
// plaintext bytes and frame results checked by a passive monitor.
module tb_crypto_stream_decrypt;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] key_seed = 8'h5A;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       s_sof = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [8:0] exp_out[$];
    logic       exp_ev[$];
    logic       bp_mode = 1'b0;
    logic       bp_payload = 1'b0;

    crypto_stream_decrypt #(.MAX_LEN(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .key_seed   (key_seed),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bp_mode) m_ready = ~m_ready;
    end

    // Monitor samples mid-cycle; values hold until the next rising edge.
    always begin
        logic [8:0] got;
        logic [8:0] exp;
        logic       exp_e;
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (m_valid && m_ready) begin
                got = {m_last, m_data};
                exp = 9'bx;
                if (exp_out.size() > 0) exp = exp_out.pop_front();
                checks++;
                assert (got === exp) else begin
                    errors++;
                    $error("FAIL out_byte observed=%h expected=%h", got, exp);
                end
            end
            if (frame_done) begin
                exp_e = 1'bx;
                if (exp_ev.size() > 0) exp_e = exp_ev.pop_front();
                checks++;
                assert (frame_err === exp_e) else begin
                    errors++;
                    $error("FAIL frame_err observed=%b expected=%b", frame_err, exp_e);
                end
            end else begin
                checks++;
                assert (frame_err === 1'b0) else begin
                    errors++;
                    $error("FAIL err_without_done observed=%b expected=0", frame_err);
                end
            end
            if (bp_payload && m_valid && !m_ready) begin
                checks++;
                assert (s_ready === 1'b0) else begin
                    errors++;
                    $error("FAIL bp_s_ready observed=%b expected=0", s_ready);
                end
            end
        end
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic sof, input logic [7:0] d);
        int unsigned n;
        logic        ok;
        n = 0;
        ok = 1'b0;
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        while (!ok && n < 200) begin
            #1;
            if (s_ready) ok = 1'b1;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        checks++;
        assert (n < 200) else begin
            errors++;
            $error("FAIL send_timeout observed=%0d expected=<200", n);
        end
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while ((exp_out.size() != 0 || exp_ev.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        assert (exp_out.size() == 0 && exp_ev.size() == 0) else begin
            errors++;
            $error("FAIL drain observed=%0d/%0d expected=0/0", exp_out.size(), exp_ev.size());
        end
    endtask

    task automatic nominal_frame(input logic [7:0] chk, input logic exp_err);
        send(1'b1, 8'h03);
        if (bp_mode) bp_payload = 1'b1;
        exp_out.push_back({1'b0, 8'hA5}); send(1'b0, 8'hFF);
        exp_out.push_back({1'b0, 8'h3C}); send(1'b0, 8'h11);
        exp_out.push_back({1'b1, 8'hFF}); send(1'b0, 8'h51);
        bp_payload = 1'b0;
        exp_ev.push_back(exp_err);        send(1'b0, chk);
    endtask

    initial begin
        #1;
        check1("rst_s_ready", s_ready, 1'b0);
        check1("rst_m_valid", m_valid, 1'b0);
        check8("rst_m_data", m_data, 8'h00);
        check1("rst_m_last", m_last, 1'b0);
        check1("rst_done", frame_done, 1'b0);
        check1("rst_err", frame_err, 1'b0);
        check1("rst_busy", busy, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("s_ready_before_edge", s_ready, 1'b0);
        @(negedge clk);
        #1;
        check1("s_ready_after_edge", s_ready, 1'b1);
        enable = 1'b0;
        #1;
        check1("enable_low_s_ready", s_ready, 1'b0);
        enable = 1'b1;
        @(negedge clk);

        // Nominal frame, then bad checksum.
        key_seed = 8'h5A;
        nominal_frame(8'h31, 1'b0);
        nominal_frame(8'h30, 1'b1);
        wait_drain();

        // Illegal length headers.
        exp_ev.push_back(1'b1); send(1'b1, 8'h00);
        check1("bad_len0_busy", busy, 1'b0);
        exp_ev.push_back(1'b1); send(1'b1, 8'h11);
        check1("bad_len17_busy", busy, 1'b0);
        wait_drain();
        check1("bad_len_no_valid", m_valid, 1'b0);

        // Output backpressure.
        bp_mode = 1'b1;
        nominal_frame(8'h31, 1'b0);
        wait_drain();
        bp_mode = 1'b0;
        m_ready = 1'b1;

        // Abort mid-frame with a new header of length 2.
        send(1'b1, 8'h03);
        exp_out.push_back({1'b0, 8'hA5}); send(1'b0, 8'hFF);
        exp_ev.push_back(1'b1);           send(1'b1, 8'h02);
        exp_out.push_back({1'b0, 8'hA5}); send(1'b0, 8'hFF);
        exp_out.push_back({1'b1, 8'h3C}); send(1'b0, 8'h11);
        exp_ev.push_back(1'b0);           send(1'b0, 8'h37);
        wait_drain();

        // Zero seed behaves as 0x01.
        key_seed = 8'h00;
        send(1'b1, 8'h01);
        exp_out.push_back({1'b1, 8'h42}); send(1'b0, 8'h43);
        exp_ev.push_back(1'b0);           send(1'b0, 8'hFA);
        wait_drain();

        // Reset mid-payload with a byte stuck in the output register.
        key_seed = 8'h5A;
        m_ready = 1'b0;
        send(1'b1, 8'h03);
        send(1'b0, 8'hFF);
        check1("pre_rst_valid", m_valid, 1'b1);
        check8("pre_rst_data", m_data, 8'hA5);
        check1("pre_rst_busy", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check1("midrst_m_valid", m_valid, 1'b0);
        check8("midrst_m_data", m_data, 8'h00);
        check1("midrst_m_last", m_last, 1'b0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_s_ready", s_ready, 1'b0);
        check1("midrst_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crypto_stream_decrypt.md
# crypto_stream_decrypt

Receive-side stream decryptor, the counterpart of the team's XOR-keystream encryptor. It accepts framed ciphertext bytes over a valid/ready stream: a plaintext length header, then the encrypted payload, then an encrypted checksum. It regenerates the keystream from a shared seed and emits plaintext bytes downstream with a last marker. At the end of each frame it reports whether the checksum matched.

## Interface
- MAX_LEN, 16, largest legal payload length in bytes (1..255)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; low stalls the input side
- key_seed  in  8  shared keystream seed, static during a frame
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid && s_ready
- s_data  in  8  input byte
- s_sof  in  1  start of frame; marks the length header byte
- m_valid  out  1  plaintext byte valid
- m_ready  in  1  downstream ready
- m_data  out  8  plaintext byte
- m_last  out  1  final payload byte of the frame
- frame_done  out  1  one-cycle pulse when a frame completes or is rejected
- frame_err  out  1  one-cycle pulse, coincident with frame_done: checksum mismatch, bad length, or abort
- busy  out  1  state is not IDLE

## Operation
- Keystream: 8-bit Galois LFSR, shifting right, tap mask 0xB8.
  - Next value: ks_next = {0, ks[7:1]} ^ (ks[0] ? 0xB8 : 0x00).
  - Effective seed: seed_eff = key_seed, or 0x01 if key_seed == 0.
- States:
  - IDLE: an accepted byte with s_sof=1 is the length header L.
    - L == 0 or L > MAX_LEN: pulse frame_done+frame_err, stay in IDLE.
    - Otherwise: store L, load ks ← seed_eff, clear checksum and count, go to PAYLOAD.
    - Accepted bytes with s_sof=0 are dropped silently.
  - PAYLOAD: each accepted byte produces plain = s_data ^ ks.
    - ks advances; checksum ^= plain; count increments.
    - plain is emitted on m_data, with m_last=1 when count == L-1; that byte moves the state to CHECK.
  - CHECK: an accepted byte c is compared: (c ^ ks) == checksum.
    - Always pulse frame_done; pulse frame_err on mismatch. Go to IDLE.
- s_ready:
  - IDLE and CHECK: s_ready = enable.
  - PAYLOAD: s_ready = enable && (!m_valid || m_ready).
- Abort: s_sof=1 on an accepted byte in PAYLOAD or CHECK.
  - Pulse frame_done+frame_err.
  - The byte is processed as a new IDLE header in the same cycle.
  - Bytes already emitted stand; no m_last is produced for the aborted frame.
- enable low: s_ready=0 and the state holds. The pending output still drains on m_ready.
- Arithmetic: L and count are 8 bits and never wrap, since L ≤ MAX_LEN ≤ 255. The checksum is the 8-bit XOR of all plaintext bytes.

## Timing
- Reset values:
  - Outputs: s_ready=0, m_valid=0, m_data=0x00, m_last=0, frame_done=0, frame_err=0, busy=0.
  - Internal: state=IDLE, ks=0x01, checksum=0, count=0.
  - s_ready may assert on the first clock edge after rst_n rises.
- Latency:
  - Accepted payload byte → m_valid high on the next cycle.
  - Accepted check or header byte → frame_done pulse on the next cycle.
- Throughput: one byte per cycle when m_ready is held high.
- Output register: m_valid holds, with m_data and m_last stable, until m_valid && m_ready. Loading a new byte in the same cycle the old one drains is permitted.
- rst_n asserted mid-frame: all state clears immediately. A partially emitted frame gets no m_last and no frame_done.
- key_seed is sampled only when the header byte is accepted.

## Structure
- Package crypto_pkg, containing:
  - LFSR_TAPS = 8'hB8;
  - the state enum (IDLE, PAYLOAD, CHECK);
  - function ks_next(ks);
  - function seed_fix(seed), mapping 0 → 1.
  - The encryptor reuses this package.
- One sub-module, crypto_keystream: holds the ks register, with load/advance controls.
- The top level holds the FSM, the count/length/checksum registers, the output register and the status pulses.

## Test plan
- Nominal frame, key_seed=0x5A, m_ready=1. Input sof+03, then FF 11 51, then check 31 → m_data A5, 3C, FF with m_last on FF; frame_done=1, frame_err=0. Keystream values used: 5A, 2D, AE, then 57 for the check byte.
- Same frame with check byte 0x30 → same payload out; frame_done=1, frame_err=1.
- Headers 0x00 and MAX_LEN+1 → frame_done+frame_err pulse, no m_valid, busy stays 0.
- Backpressure: m_ready toggled 1/0 every cycle during the nominal frame → s_ready low while the output is blocked; data A5 3C FF exactly once each, in order.
- Abort: sof+03, FF, then sof+02 → error pulse, A5 emitted without m_last, new frame decoded correctly from seed 0x5A.
- Edge cases:
  - key_seed=0x00 → keystream starts at 0x01.
  - rst_n low mid-PAYLOAD → all outputs 0 on the same edge; busy=0.
